rf_write_arbiter: RTL

Shares the register file's single write port between two writeback requesters: A is execute/ALU results and B is memory load returns. Arbitration is round-robin. The block drives a registered write strobe, address and data into the register file's enable-gated storage flops. It sits between the writeback stage sources and the register file, and honours a pipeline-wide hold.

---
 rtl/rf_write_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// execute results (A) and load returns (B), with a registered write stage.
module rf_write_arbiter #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 3,
  parameter int R0_WRITABLE = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              hold,
  input  logic              a_vld,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_rdy,
  input  logic              b_vld,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_rdy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              prio_b
);

  typedef enum logic {
    FAV_A = 1'b0,
    FAV_B = 1'b1
  } prio_t;

  prio_t state;
  prio_t state_nxt;

  logic              grant_a_p0;
  logic              grant_b_p0;
  logic              xfer_p0;
  logic [ADDR_W-1:0] win_addr_p0;
  logic [DATA_W-1:0] win_data_p0;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;

  // Address 0 is a hard-wired zero register unless configured writable.
  function automatic logic write_allowed(input logic [ADDR_W-1:0] addr);
    return (R0_WRITABLE != 0) || (addr != '0);
  endfunction

  // Stage 0: combinational grant and winner selection.
  always_comb begin
    grant_a_p0 = !hold && a_vld && (!b_vld || (state == FAV_A));
    grant_b_p0 = !hold && b_vld && (!a_vld || (state == FAV_B));
    xfer_p0    = grant_a_p0 || grant_b_p0;
    if (grant_b_p0) begin
      win_addr_p0 = b_addr;
      win_data_p0 = b_data;
    end else begin
      win_addr_p0 = a_addr;
      win_data_p0 = a_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= FAV_A;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (grant_a_p0) begin
      state_nxt = FAV_B;
    end else if (grant_b_p0) begin
      state_nxt = FAV_A;
    end
  end

  always_comb begin
    a_rdy  = grant_a_p0;
    b_rdy  = grant_b_p0;
    prio_b = (state == FAV_B);
  end

  // Stage 1: registered write port; address/data hold when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= xfer_p0 && write_allowed(win_addr_p0);
      if (xfer_p0) begin
        addr_p1 <= win_addr_p0;
        data_p1 <= win_data_p0;
      end
    end
  end

  assign wr_en   = vld_p1;
  assign wr_addr = addr_p1;
  assign wr_data = data_p1;

endmodule
